// File: rtl/fx2_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fx2_burst_reader
// Description : Reads exactly PKT_WORDS words per flagged packet from the rx
//               FIFO into a 2-entry skid and streams them on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fx2_burst_reader #(
  parameter int PKT_WORDS = 256,
  parameter int CNT_W     = 9,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        packet_rdy,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        burst_active,
  output logic        pkt_done,
  output logic [15:0] pkt_count,
  output logic        underflow,
  output logic        aborted,
  input  logic        clear_status
);

  localparam int               c_stall_w    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_pkt        = CNT_W'(PKT_WORDS);
  localparam logic [CNT_W-1:0] c_last       = CNT_W'(PKT_WORDS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [c_stall_w-1:0] c_to_m1  = c_stall_w'(TIMEOUT - 1);
  localparam logic [c_stall_w-1:0] c_st_one = c_stall_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     sent_q, sent_d;
  logic [15:0]          skid_q [2];
  logic [15:0]          skid_d [2];
  logic                 head_q, head_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [c_stall_w-1:0] stall_q, stall_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic                 underflow_q, underflow_d;
  logic                 aborted_q, aborted_d;

  logic w_active;
  logic w_valid;
  logic w_accept;
  logic w_stall;
  logic w_timeout;
  logic w_room;
  logic w_rd;
  logic w_push;
  logic w_tail;

  assign w_active  = (state_q == S_BURST) || (state_q == S_DRAIN);
  assign w_valid   = |occ_q;
  assign w_accept  = w_valid & out_ready;
  assign w_stall   = w_active & w_valid & ~out_ready;
  assign w_timeout = w_stall & (stall_q == c_to_m1);
  // A word leaving this cycle frees its slot, keeping 1 word/cycle throughput.
  assign w_room    = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, w_accept}) < 3'd2;
  assign w_rd      = (state_q == S_BURST) & (issued_q != c_pkt) & w_room & ~w_timeout;
  assign w_push    = inflight_q & w_active;
  assign w_tail    = head_q ^ occ_q[0];

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    skid_d      = skid_q;
    head_d      = head_q;
    occ_d       = occ_q;
    inflight_d  = w_rd;
    stall_d     = stall_q;
    pkt_done_d  = 1'b0;
    pkt_count_d = pkt_count_q;
    underflow_d = underflow_q;
    aborted_d   = aborted_q;

    if (w_push) begin
      skid_d[w_tail] = fifo_dout;
    end
    if (w_accept) begin
      head_d = ~head_q;
      sent_d = sent_q + c_cnt_one;
    end
    occ_d = occ_q + {1'b0, w_push} - {1'b0, w_accept};
    if (w_rd) begin
      issued_d = issued_q + c_cnt_one;
    end

    if (!w_active || w_accept) begin
      stall_d = '0;
    end else if (w_stall) begin
      stall_d = stall_q + c_st_one;
    end

    if (w_rd && fifo_empty) begin
      underflow_d = 1'b1;
    end else if (clear_status) begin
      underflow_d = 1'b0;
    end
    if (w_timeout) begin
      aborted_d = 1'b1;
    end else if (clear_status) begin
      aborted_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && packet_rdy) begin
          state_d  = S_BURST;
          issued_d = '0;
          sent_d   = '0;
        end
      end
      S_BURST: begin
        if (issued_d == c_pkt) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_accept && (sent_q == c_last)) begin
          state_d     = S_DONE;
          pkt_done_d  = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abandon the burst: words still in the FIFO are left for the resync path.
    if (w_timeout) begin
      state_d    = S_IDLE;
      occ_d      = '0;
      head_d     = 1'b0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      sent_q      <= '0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      head_q      <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      stall_q     <= '0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      underflow_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      skid_q      <= skid_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      stall_q     <= stall_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
      underflow_q <= underflow_d;
      aborted_q   <= aborted_d;
    end
  end

  assign fifo_rd      = w_rd;
  assign out_data     = skid_q[head_q];
  assign out_valid    = w_valid;
  assign out_last     = w_valid & (sent_q == c_last);
  assign burst_active = w_active;
  assign pkt_done     = pkt_done_q;
  assign pkt_count    = pkt_count_q;
  assign underflow    = underflow_q;
  assign aborted      = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fx2_burst_reader
// Description : Directed, table-driven bench for fx2_burst_reader with a
//               behavioural FIFO (registered read data, 16'hEEEE when empty).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fx2_burst_reader;

  localparam int PKT = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        packet_rdy = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        fifo_rd;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        burst_active;
  logic        pkt_done;
  logic [15:0] pkt_count;
  logic        underflow;
  logic        aborted;
  logic        clear_status = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [4096];
  int rp = 0;
  int wp = 0;

  fx2_burst_reader #(.PKT_WORDS(PKT), .CNT_W(9), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .packet_rdy(packet_rdy),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .burst_active(burst_active), .pkt_done(pkt_done),
    .pkt_count(pkt_count), .underflow(underflow), .aborted(aborted),
    .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rp >= wp);

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (rp < wp) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 1;
      end else begin
        fifo_dout <= 16'hEEEE;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".fifo_rd"},      int'(fifo_rd),      0);
    chk({tag, ".out_valid"},    int'(out_valid),    0);
    chk({tag, ".out_last"},     int'(out_last),     0);
    chk({tag, ".burst_active"}, int'(burst_active), 0);
    chk({tag, ".pkt_done"},     int'(pkt_done),     0);
    chk({tag, ".pkt_count"},    int'(pkt_count),    0);
    chk({tag, ".out_data"},     int'(out_data),     0);
    chk({tag, ".underflow"},    int'(underflow),    0);
    chk({tag, ".aborted"},      int'(aborted),      0);
  endtask

  // results of the most recent run_burst
  int acc_n, rd_n, data_err, last_err, max_out, done_gap, span, lat;
  int empty_at_rd, start_rp, start_wp;
  bit done_seen, ufl_early, abort_seen;

  // mode 0: out_ready held 1; mode 1: toggles 1,0,1,0; mode 2: ready 1, enable dropped at word 100
  task automatic run_burst(input int mode);
    int first_rd, first_vld, first_acc, last_acc;
    logic [15:0] exp;
    start_rp = rp; start_wp = wp;
    acc_n = 0; rd_n = 0; data_err = 0; last_err = 0; max_out = 0;
    done_seen = 0; done_gap = -1; ufl_early = 0; abort_seen = 0; empty_at_rd = -1;
    first_rd = -1; first_vld = -1; first_acc = -1; last_acc = -1;
    enable = 1'b1; packet_rdy = 1'b1;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (mode == 2 && acc_n == 100) enable = 1'b0;
      @(negedge clk);
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = cyc;
        if (fifo_empty && empty_at_rd < 0) begin
          empty_at_rd = rd_n;
          ufl_early = underflow;
        end
        rd_n++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        exp = (start_rp + acc_n < start_wp) ? mem[start_rp + acc_n] : 16'hEEEE;
        if (out_data !== exp) data_err++;
        if (out_last !== (acc_n == PKT - 1)) last_err++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_n++;
      end
      if (rd_n - acc_n > max_out) max_out = rd_n - acc_n;
      if (aborted) abort_seen = 1;
      if (pkt_done) begin
        done_seen = 1;
        done_gap = cyc - last_acc;
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    span = last_acc - first_acc;
    lat = first_vld - first_rd;
  endtask

  task automatic check_burst(input string tag, input int exp_cnt, input bit exp_ufl, input int exp_span);
    chk({tag, ".words"},      acc_n, PKT);
    chk({tag, ".reads"},      rd_n, PKT);
    chk({tag, ".data_errs"},  data_err, 0);
    chk({tag, ".last_errs"},  last_err, 0);
    chk({tag, ".occ_le_2"},   int'(max_out <= 2), 1);
    chk({tag, ".done_seen"},  int'(done_seen), 1);
    chk({tag, ".done_gap"},   done_gap, 1);
    chk({tag, ".done_width"}, int'(pkt_done), 0);
    chk({tag, ".pkt_count"},  int'(pkt_count), exp_cnt);
    chk({tag, ".underflow"},  int'(underflow), int'(exp_ufl));
    chk({tag, ".aborted"},    int'(abort_seen), 0);
    chk({tag, ".valid_lat"},  lat, 2);
    if (exp_ufl) begin
      chk({tag, ".ufl_before"},  int'(ufl_early), 0);
      chk({tag, ".first_empty"}, empty_at_rd, 100);
    end
    if (exp_span >= 0) chk({tag, ".span"}, span, exp_span);
  endtask

  typedef struct {
    string       name;
    int          mode;
    int          fill;      // >0: FIFO holds only this many words for the burst
    bit          exp_ufl;
    int          exp_cnt;
    int          exp_span;  // -1: accept spacing not checked
  } vec_t;

  vec_t vecs [3];

  initial begin
    int stall, acc, busy, done_cnt;
    vecs[0] = '{"full_rate", 0, 0,   1'b0, 1, 255};
    vecs[1] = '{"toggle",    1, 0,   1'b0, 2, -1};
    vecs[2] = '{"underflow", 0, 100, 1'b1, 3, 255};

    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    wp = 512;

    #2 reset = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].fill > 0) wp = rp + vecs[i].fill;
      run_burst(vecs[i].mode);
      check_burst(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_ufl, vecs[i].exp_span);
      repeat (2) @(posedge clk);
      #1;
    end

    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    chk("clear.underflow", int'(underflow), 0);

    // stall after 10 words until TIMEOUT=16 aborts the burst
    wp = rp + 300;
    enable = 1'b1; packet_rdy = 1'b1;
    stall = 0; acc = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      out_ready = (acc < 10);
      if (cyc == 2) enable = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) acc++;
      if (out_valid && !out_ready && burst_active) begin
        stall++;
        if (stall == 16) chk("timeout.not_early", int'(aborted), 0);
      end
      if (pkt_done) done_cnt++;
      @(posedge clk); #1;
      if (stall == 16) break;
    end
    chk("timeout.stall_cycles", stall, 16);
    chk("timeout.aborted",      int'(aborted), 1);
    chk("timeout.burst_active", int'(burst_active), 0);
    chk("timeout.out_valid",    int'(out_valid), 0);
    chk("timeout.fifo_rd",      int'(fifo_rd), 0);
    chk("timeout.words",        acc, 10);
    chk("timeout.no_done",      done_cnt, 0);
    chk("timeout.pkt_count",    int'(pkt_count), 3);
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    chk("timeout.clear", int'(aborted), 0);

    // reset asserted on word 50 of a burst
    wp = rp + 600;
    enable = 1'b1; packet_rdy = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 400 && acc < 50; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) acc++;
      if (acc < 50) begin
        @(posedge clk); #1;
      end
    end
    chk("midreset.words_before", acc, 50);
    reset = 1'b1;
    enable = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_burst(0);
    check_burst("after_reset", 1, 1'b0, 255);
    repeat (2) @(posedge clk);
    #1;

    // enable dropped at word 100, then no new burst while enable is low
    wp = rp + 600;
    run_burst(2);
    check_burst("enable_drop", 2, 1'b0, 255);
    packet_rdy = 1'b1;
    busy = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (burst_active || fifo_rd) busy++;
    end
    chk("enable_drop.no_restart", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
